// File: rtl/cordic_share_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cordic_pkg
//  Description : Shared state encodings and default sizes for the CORDIC
//                scheduler and the CORDIC core wrapper.
//  Revision    : 1.0  initial release
// ============================================================================
package cordic_pkg;

    localparam int c_N_REQ = 4;
    localparam int c_DW    = 17;
    localparam int c_LAT   = 18;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_START = c_ST_START,
        ST_BUSY  = c_ST_BUSY,
        ST_DONE  = c_ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_share_sched_if.sv
`default_nettype none
// ============================================================================
//  Interface   : cordic_share_sched_if
//  Description : Requester, CORDIC core and response signals of the scheduler.
//                slave = scheduler side, master = requesters/core/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface cordic_share_sched_if
    import cordic_pkg::*;
#(
    parameter int N_REQ = c_N_REQ,
    parameter int DW    = c_DW,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_x;
    logic [N_REQ*DW-1:0] req_y;
    logic                core_rst;
    logic                core_start;
    logic [DW-1:0]       core_x;
    logic [DW-1:0]       core_y;
    logic [DW-1:0]       core_x_o;
    logic [DW-1:0]       core_y_o;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_mag;
    logic [DW-1:0]       rsp_theta;
    logic                busy;

    modport slave (
        input  req_valid, req_x, req_y, core_x_o, core_y_o, rsp_ready,
        output req_ready, core_rst, core_start, core_x, core_y,
               rsp_valid, rsp_id, rsp_mag, rsp_theta, busy
    );

    modport master (
        output req_valid, req_x, req_y, core_x_o, core_y_o, rsp_ready,
        input  req_ready, core_rst, core_start, core_x, core_y,
               rsp_valid, rsp_id, rsp_mag, rsp_theta, busy
    );
endinterface
`default_nettype wire

// File: rtl/cordic_share_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin pick: first set request at or after the pointer,
//                wrapping from N_REQ-1 back to 0. One-hot grant plus index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDW-1:0]   i_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [IDW-1:0]   o_idx,
    output logic                  o_any
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            // Pointer plus offset stays below 2*N_REQ, so one subtract wraps it.
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IDW'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_share_sched
//  Description : Shares one iterative CORDIC vectoring core among N_REQ
//                requesters with round-robin arbitration and a fixed-latency
//                iteration counter; results are returned tagged by requester.
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_share_sched
    import cordic_pkg::*;
#(
    parameter int N_REQ = c_N_REQ,
    parameter int DW    = c_DW,
    parameter int LAT   = c_LAT,
    parameter int IDW   = $clog2(N_REQ)
) (
    input wire logic            clk,
    input wire logic            rst,
    cordic_share_sched_if.slave bus
);

    localparam int              c_CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(LAT - 1);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [c_CW-1:0] r_cnt;
    logic            r_core_rst;
    logic            r_core_start;
    logic [DW-1:0]   r_core_x;
    logic [DW-1:0]   r_core_y;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_mag;
    logic [DW-1:0]   r_rsp_theta;
    logic            r_busy;

    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic             w_accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A grant during a reset cycle would be lost, so it is never offered.
    assign w_accept      = (r_state == ST_IDLE) && !rst && w_any;
    assign bus.req_ready = w_accept ? w_grant : '0;

    assign bus.core_rst   = r_core_rst;
    assign bus.core_start = r_core_start;
    assign bus.core_x     = r_core_x;
    assign bus.core_y     = r_core_y;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_mag    = r_rsp_mag;
    assign bus.rsp_theta  = r_rsp_theta;
    assign bus.busy       = r_busy;

    always_ff @(posedge clk) begin
        r_core_rst <= rst;
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_core_start <= 1'b0;
            r_core_x     <= '0;
            r_core_y     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_mag    <= '0;
            r_rsp_theta  <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id         <= w_idx;
                        r_core_x     <= bus.req_x[int'(w_idx)*DW +: DW];
                        r_core_y     <= bus.req_y[int'(w_idx)*DW +: DW];
                        r_core_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    r_core_start <= 1'b0;
                    r_cnt        <= '0;
                    r_ptr        <= (int'(r_id) == N_REQ - 1) ? '0 : r_id + IDW'(1);
                    r_state      <= ST_BUSY;
                end
                ST_BUSY: begin
                    // Last count lands exactly LAT cycles after the start pulse.
                    if (r_cnt == c_CNT_LAST) begin
                        r_rsp_mag   <= bus.core_x_o;
                        r_rsp_theta <= bus.core_y_o;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_share_sched
//  Description : Scoreboard bench for cordic_share_sched with a behavioural
//                CORDIC core stand-in and a cycle-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_share_sched;
    import cordic_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 17;
    localparam int LAT = 18;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_share_sched_if #(.N_REQ(N), .DW(DW), .IDW(IDW)) bus ();

    cordic_share_sched #(
        .N_REQ (N),
        .DW    (DW),
        .LAT   (LAT),
        .IDW   (IDW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  mag;
        logic [DW-1:0]  th;
    } rsp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } core_op_t;

    rsp_t     sb[$];
    core_op_t core_q[$];

    // Reference model state
    bit            m_active   = 1'b0;
    int            m_gcyc     = 0;
    int            m_ptr      = 0;
    bit            m_prev_rst = 1'b1;
    logic [DW-1:0] m_opx, m_opy;
    int            n_grants   = 0;

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [N-1:0]  last_ready = '0;

    bit auto_en  = 1'b0;
    int auto_pct = 0;
    bit rnd_rsp  = 1'b0;

    // Stand-in core results: any deterministic function of the operands.
    function automatic logic [DW-1:0] f_mag(logic [DW-1:0] x, logic [DW-1:0] y);
        return x + y;
    endfunction

    function automatic logic [DW-1:0] f_th(logic [DW-1:0] x, logic [DW-1:0] y);
        return x ^ y;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Monitor, scoreboard and core stand-in, all sampled mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int           win;
        bit           exp_start, exp_rv;
        exp_ready = '0;
        win       = -1;
        if (!m_active && !rst) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && bus.req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) exp_ready[win] = 1'b1;
        end
        exp_start = m_active && (cyc == m_gcyc + 1);
        exp_rv    = m_active && (cyc >= m_gcyc + LAT + 2);

        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("core_start", 64'(bus.core_start), 64'(exp_start));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        chk("busy", 64'(bus.busy), 64'(m_active));
        chk("core_rst", 64'(bus.core_rst), 64'(m_prev_rst));
        if (m_active && cyc > m_gcyc) begin
            chk("core_x", 64'(bus.core_x), 64'(m_opx));
            chk("core_y", 64'(bus.core_y), 64'(m_opy));
        end
        if (exp_rv && sb.size() > 0) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
            chk("rsp_mag", 64'(bus.rsp_mag), 64'(sb[0].mag));
            chk("rsp_theta", 64'(bus.rsp_theta), 64'(sb[0].th));
        end
        last_ready = bus.req_ready;

        // Core outputs carry the true result only in the cycle LAT after start.
        if (core_q.size() > 0 && core_q[0].due == cyc) begin
            bus.core_x_o = f_mag(core_q[0].x, core_q[0].y);
            bus.core_y_o = f_th(core_q[0].x, core_q[0].y);
            void'(core_q.pop_front());
        end else begin
            bus.core_x_o = DW'($urandom);
            bus.core_y_o = DW'($urandom);
        end
        if (bus.core_start === 1'b1) begin
            core_op_t op;
            op.due = cyc + LAT;
            op.x   = bus.core_x;
            op.y   = bus.core_y;
            core_q.push_back(op);
        end

        if (rst) begin
            m_active   = 1'b0;
            m_ptr      = 0;
            m_prev_rst = 1'b1;
            sb.delete();
            core_q.delete();
        end else begin
            m_prev_rst = 1'b0;
            if (win >= 0) begin
                rsp_t r;
                m_active = 1'b1;
                m_gcyc   = cyc;
                m_opx    = bus.req_x[win*DW +: DW];
                m_opy    = bus.req_y[win*DW +: DW];
                r.id     = IDW'(win);
                r.mag    = f_mag(m_opx, m_opy);
                r.th     = f_th(m_opx, m_opy);
                sb.push_back(r);
                m_ptr    = (win + 1) % N;
                n_grants++;
            end else if (exp_rv && bus.rsp_ready) begin
                void'(sb.pop_front());
                m_active = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~last_ready;
        if (auto_en) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(99) < auto_pct) begin
                    bus.req_x[i*DW +: DW] = DW'($urandom);
                    bus.req_y[i*DW +: DW] = DW'($urandom);
                    bus.req_valid[i]      = 1'b1;
                end
            end
        end
        if (rnd_rsp) bus.rsp_ready = ($urandom_range(99) < 70);
    endtask

    task automatic issue(int i, logic [DW-1:0] x, logic [DW-1:0] y);
        bus.req_x[i*DW +: DW] = x;
        bus.req_y[i*DW +: DW] = y;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 600; t++) begin
            if (bus.req_valid == '0 && !m_active) return;
            step();
        end
        $display("FAIL wait_idle timeout cycle %0d: got pending work expected idle", cyc);
        $fatal(1);
    endtask

    task automatic wait_rsp_valid();
        for (int t = 0; t < 100; t++) begin
            if (bus.rsp_valid === 1'b1) return;
            step();
        end
        $display("FAIL wait_rsp_valid timeout cycle %0d: got 0 expected 1", cyc);
        $fatal(1);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        int g;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b1;
        bus.core_x_o  = '0;
        bus.core_y_o  = '0;
        repeat (3) step();
        rst = 1'b0;

        // Single request from requester 1
        issue(1, 17'd100, 17'd0);
        wait_idle();

        // All four requesting continuously out of reset
        rst = 1'b1;
        for (int i = 0; i < N; i++) issue(i, DW'($urandom), DW'($urandom));
        step();
        step();
        rst      = 1'b0;
        auto_en  = 1'b1;
        auto_pct = 100;
        g        = n_grants;
        for (int t = 0; t < 200 && n_grants < g + 5; t++) step();
        auto_en = 1'b0;
        wait_idle();

        // Backpressure in DONE with another requester waiting behind a busy core
        bus.rsp_ready = 1'b0;
        issue(2, 17'h1ABCD, 17'h00F0F);
        step();
        step();
        issue(0, 17'h12345, 17'h0FFFF);
        wait_rsp_valid();
        repeat (10) step();
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Pointer wrap: only 3, then only 0, then everyone (1 must win first)
        do_reset(2);
        issue(3, 17'h00011, 17'h00022);
        wait_idle();
        issue(0, 17'h1FFFF, 17'h00001);
        wait_idle();
        for (int i = 0; i < N; i++) issue(i, DW'($urandom), DW'($urandom));
        wait_idle();

        // Reset while the iteration counter is at 7
        issue(2, 17'h0AAAA, 17'h05555);
        for (int t = 0; t < 10 && !m_active; t++) step();
        g = m_gcyc;
        for (int t = 0; t < 40 && cyc < g + 9; t++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();
        for (int i = 0; i < N; i++) issue(i, DW'($urandom), DW'($urandom));
        wait_idle();

        // Random traffic with random response backpressure
        auto_en  = 1'b1;
        auto_pct = 25;
        rnd_rsp  = 1'b1;
        repeat (1500) step();
        auto_en       = 1'b0;
        rnd_rsp       = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
